// File: rtl/vx_wb_pkg.sv
// Shared constants and payload types for the commit-to-writeback arbiter.
package vx_wb_pkg;

    localparam int unsigned NUM_REQS    = 6;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned DATA_W      = NUM_THREADS * 32;
    localparam int unsigned NW_BITS     = 2;
    localparam int unsigned NR_BITS     = 6;
    localparam int unsigned PERF_CTR_W  = 44;
    localparam int unsigned REQ_IDX_W   = $clog2(NUM_REQS);

    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_LD  = 1;
    localparam int unsigned WB_SRC_ST  = 2;
    localparam int unsigned WB_SRC_CSR = 3;
    localparam int unsigned WB_SRC_FPU = 4;
    localparam int unsigned WB_SRC_GPU = 5;

    typedef struct packed {
        logic [NW_BITS-1:0]     wid;
        logic [31:0]            pc;
        logic [NUM_THREADS-1:0] tmask;
        logic [NR_BITS-1:0]     rd;
        logic                   wb;
        logic [DATA_W-1:0]      data;
        logic                   eop;
    } wb_beat_t;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin successor of a source index, wrapping at the last source.
    function automatic logic [REQ_IDX_W-1:0] wb_next_ptr(input logic [REQ_IDX_W-1:0] idx);
        return (idx == REQ_IDX_W'(NUM_REQS - 1)) ? '0 : idx + REQ_IDX_W'(1);
    endfunction

endpackage

// File: rtl/vx_writeback_arb_if.sv
// Commit-side and writeback-side signals of the writeback arbiter.
// master = arbiter (drives req_ready and wb_*), slave = commit units / register file.
interface vx_writeback_arb_if;
    import vx_wb_pkg::*;

    logic [NUM_REQS-1:0]             req_valid;
    logic [NUM_REQS*NW_BITS-1:0]     req_wid;
    logic [NUM_REQS*32-1:0]          req_pc;
    logic [NUM_REQS*NUM_THREADS-1:0] req_tmask;
    logic [NUM_REQS*NR_BITS-1:0]     req_rd;
    logic [NUM_REQS-1:0]             req_wb;
    logic [NUM_REQS*DATA_W-1:0]      req_data;
    logic [NUM_REQS-1:0]             req_eop;
    logic [NUM_REQS-1:0]             req_ready;

    logic                   wb_valid;
    logic [NW_BITS-1:0]     wb_wid;
    logic [31:0]            wb_pc;
    logic [NUM_THREADS-1:0] wb_tmask;
    logic [NR_BITS-1:0]     wb_rd;
    logic                   wb_wb;
    logic [DATA_W-1:0]      wb_data;
    logic                   wb_eop;
    logic                   wb_ready;

    modport master (
        input  req_valid, req_wid, req_pc, req_tmask, req_rd, req_wb, req_data, req_eop,
        output req_ready,
        output wb_valid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_wb, wb_data, wb_eop,
        input  wb_ready
    );

    modport slave (
        output req_valid, req_wid, req_pc, req_tmask, req_rd, req_wb, req_data, req_eop,
        input  req_ready,
        input  wb_valid, wb_wid, wb_pc, wb_tmask, wb_rd, wb_wb, wb_data, wb_eop,
        output wb_ready
    );

endinterface

// File: rtl/vx_rr_lock_arbiter.sv
// Round-robin arbiter with a sticky lock for multi-beat owners.
// Purely combinational; the caller owns the pointer and lock state.
module vx_rr_lock_arbiter #(
    parameter  int unsigned NUM_REQS = 6,
    localparam int unsigned IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic [NUM_REQS-1:0] valid_i,
    input  logic                lock_i,
    input  logic [IDX_W-1:0]    lock_idx_i,
    input  logic [IDX_W-1:0]    rr_ptr_i,
    output logic [NUM_REQS-1:0] grant_c_o,
    output logic [IDX_W-1:0]    grant_idx_c_o
);

    logic              found;
    int unsigned       cand;
    logic [IDX_W-1:0]  cand_idx;

    // Locked owner excludes everyone, even while it bubbles; otherwise scan up from rr_ptr.
    always_comb begin
        grant_c_o     = '0;
        grant_idx_c_o = '0;
        found         = 1'b0;
        cand          = 0;
        cand_idx      = '0;
        if (lock_i) begin
            if (valid_i[lock_idx_i]) begin
                grant_c_o[lock_idx_i] = 1'b1;
                grant_idx_c_o         = lock_idx_i;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REQS; k++) begin
                cand = 32'(rr_ptr_i) + k;
                if (cand >= NUM_REQS) begin
                    cand = cand - NUM_REQS;
                end
                cand_idx = IDX_W'(cand);
                if (!found && valid_i[cand_idx]) begin
                    found               = 1'b1;
                    grant_c_o[cand_idx] = 1'b1;
                    grant_idx_c_o       = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/vx_writeback_arb.sv
// Merges the per-unit commit streams onto the single register-file writeback port
// through a registered, backpressured output stage with a saturating stall counter.
module vx_writeback_arb
    import vx_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    vx_writeback_arb_if.master    wb_bus,
    output logic [PERF_CTR_W-1:0] perf_wb_stalls
);

    wb_beat_t               req_beat_c [NUM_REQS];
    logic [NUM_REQS-1:0]    grant_c;
    logic [REQ_IDX_W-1:0]   grant_idx_c;
    logic                   lock_c;
    logic                   stall_c;
    logic [NUM_REQS-1:0]    ready_c;
    logic                   accept_c;
    logic                   stall_evt_c;
    wb_beat_t               win_beat_c;

    arb_state_e             state_q,    state_d;
    logic [REQ_IDX_W-1:0]   lock_idx_q, lock_idx_d;
    logic [REQ_IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic                   wb_valid_q, wb_valid_d;
    wb_beat_t               wb_beat_q,  wb_beat_d;
    logic [PERF_CTR_W-1:0]  perf_q,     perf_d;

    // Slice the flat per-source buses into beat structs.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            req_beat_c[i].wid   = wb_bus.req_wid[i*NW_BITS +: NW_BITS];
            req_beat_c[i].pc    = wb_bus.req_pc[i*32 +: 32];
            req_beat_c[i].tmask = wb_bus.req_tmask[i*NUM_THREADS +: NUM_THREADS];
            req_beat_c[i].rd    = wb_bus.req_rd[i*NR_BITS +: NR_BITS];
            req_beat_c[i].wb    = wb_bus.req_wb[i];
            req_beat_c[i].data  = wb_bus.req_data[i*DATA_W +: DATA_W];
            req_beat_c[i].eop   = wb_bus.req_eop[i];
        end
    end

    assign lock_c = (state_q == ARB_LOCKED);

    vx_rr_lock_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .valid_i       (wb_bus.req_valid),
        .lock_i        (lock_c),
        .lock_idx_i    (lock_idx_q),
        .rr_ptr_i      (rr_ptr_q),
        .grant_c_o     (grant_c),
        .grant_idx_c_o (grant_idx_c)
    );

    assign stall_c     = wb_valid_q & ~wb_bus.wb_ready;
    assign ready_c     = grant_c & {NUM_REQS{~stall_c}};
    assign accept_c    = |(wb_bus.req_valid & ready_c);
    assign win_beat_c  = req_beat_c[grant_idx_c];
    assign stall_evt_c = |(wb_bus.req_valid & ~ready_c);

    // Reset is kept out of the state path; it only masks the visible ready.
    assign wb_bus.req_ready = reset ? ready_c : '0;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        wb_valid_d = wb_valid_q;
        wb_beat_d  = wb_beat_q;
        perf_d     = perf_q;
        if (!stall_c) begin
            wb_valid_d = accept_c;
            if (accept_c) begin
                wb_beat_d = win_beat_c;
                if (win_beat_c.eop) begin
                    state_d  = ARB_FREE;
                    rr_ptr_d = wb_next_ptr(grant_idx_c);
                end else begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = grant_idx_c;
                end
            end
        end
        if (stall_evt_c && (perf_q != '1)) begin
            perf_d = perf_q + PERF_CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_FREE;
            lock_idx_q <= REQ_IDX_W'(WB_SRC_ALU);
            rr_ptr_q   <= REQ_IDX_W'(WB_SRC_ALU);
            wb_valid_q <= 1'b0;
            wb_beat_q  <= '0;
            perf_q     <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_beat_q  <= wb_beat_d;
            perf_q     <= perf_d;
        end
    end

    assign wb_bus.wb_valid = wb_valid_q;
    assign wb_bus.wb_wid   = wb_beat_q.wid;
    assign wb_bus.wb_pc    = wb_beat_q.pc;
    assign wb_bus.wb_tmask = wb_beat_q.tmask;
    assign wb_bus.wb_rd    = wb_beat_q.rd;
    assign wb_bus.wb_wb    = wb_beat_q.wb;
    assign wb_bus.wb_data  = wb_beat_q.data;
    assign wb_bus.wb_eop   = wb_beat_q.eop;
    assign perf_wb_stalls  = perf_q;

    // Sources obey valid/ready, and the arbiter never accepts two beats at once.
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_hold_chk
        a_valid_hold: assert property (@(posedge clk) disable iff (!reset)
            (wb_bus.req_valid[gi] && !ready_c[gi]) |=> wb_bus.req_valid[gi]);
    end

    a_one_accept: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(wb_bus.req_valid & ready_c));

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Randomized and directed bench for vx_writeback_arb against a queue-free
// behavioural model of the grant, lock and output-register rules.
module tb_vx_writeback_arb;
    import vx_wb_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [PERF_CTR_W-1:0] perf_wb_stalls;

    vx_writeback_arb_if bus ();

    vx_writeback_arb dut (
        .clk            (clk),
        .reset          (reset),
        .wb_bus         (bus),
        .perf_wb_stalls (perf_wb_stalls)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic     src_vld  [NUM_REQS];
    wb_beat_t src_beat [NUM_REQS];
    logic     tb_wb_ready;

    // Reference model state
    bit              m_wb_valid;
    wb_beat_t        m_beat;
    bit              m_lock;
    int              m_lock_idx;
    int              m_rr;
    longint unsigned m_perf;
    int              last_acc;
    logic [NUM_REQS-1:0] obs_ready;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_beat_t mk_beat(input logic [31:0] pc, input logic eop);
        wb_beat_t b;
        b.wid   = NW_BITS'($urandom());
        b.pc    = pc;
        b.tmask = NUM_THREADS'($urandom());
        b.rd    = NR_BITS'($urandom());
        b.wb    = 1'b1;
        b.data  = '0;
        for (int t = 0; t < NUM_THREADS; t++) b.data[t*32 +: 32] = $urandom();
        b.eop   = eop;
        return b;
    endfunction

    function automatic wb_beat_t rand_beat(input logic eop);
        wb_beat_t b;
        b    = mk_beat($urandom(), eop);
        b.wb = 1'($urandom_range(0, 1));
        return b;
    endfunction

    task automatic model_reset();
        m_wb_valid = 1'b0;
        m_beat     = '0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
        m_rr       = 0;
        m_perf     = 0;
        last_acc   = -1;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQS; i++) begin
            bus.req_valid[i]                          = src_vld[i];
            bus.req_wid[i*NW_BITS +: NW_BITS]         = src_beat[i].wid;
            bus.req_pc[i*32 +: 32]                    = src_beat[i].pc;
            bus.req_tmask[i*NUM_THREADS +: NUM_THREADS] = src_beat[i].tmask;
            bus.req_rd[i*NR_BITS +: NR_BITS]          = src_beat[i].rd;
            bus.req_wb[i]                             = src_beat[i].wb;
            bus.req_data[i*DATA_W +: DATA_W]          = src_beat[i].data;
            bus.req_eop[i]                            = src_beat[i].eop;
        end
        bus.wb_ready = tb_wb_ready;
    endtask

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic step();
        int                  g;
        bit                  stall;
        logic [NUM_REQS-1:0] vld;
        logic [NUM_REQS-1:0] exp_ready;
        wb_beat_t            obs_beat;
        drive();
        @(negedge clk);
        for (int i = 0; i < NUM_REQS; i++) vld[i] = src_vld[i];
        g = -1;
        if (m_lock) begin
            if (vld[m_lock_idx]) g = m_lock_idx;
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                int j;
                j = (m_rr + k) % int'(NUM_REQS);
                if (g < 0 && vld[j]) g = j;
            end
        end
        stall     = m_wb_valid && !tb_wb_ready;
        exp_ready = '0;
        if (g >= 0 && !stall) exp_ready[g] = 1'b1;
        obs_ready = bus.req_ready;
        check("req_ready", 192'(bus.req_ready), 192'(exp_ready));
        check("wb_valid", 192'(bus.wb_valid), 192'(m_wb_valid));
        if (m_wb_valid) begin
            obs_beat.wid   = bus.wb_wid;
            obs_beat.pc    = bus.wb_pc;
            obs_beat.tmask = bus.wb_tmask;
            obs_beat.rd    = bus.wb_rd;
            obs_beat.wb    = bus.wb_wb;
            obs_beat.data  = bus.wb_data;
            obs_beat.eop   = bus.wb_eop;
            check("wb_beat", 192'(obs_beat), 192'(m_beat));
        end
        check("perf", 192'(perf_wb_stalls), 192'(m_perf));
        if ((vld & ~exp_ready) != '0) m_perf++;
        last_acc = -1;
        if (!stall) begin
            if (exp_ready != '0) begin
                last_acc   = g;
                m_wb_valid = 1'b1;
                m_beat     = src_beat[g];
                if (src_beat[g].eop) begin
                    m_lock = 1'b0;
                    m_rr   = (g + 1) % int'(NUM_REQS);
                end else begin
                    m_lock     = 1'b1;
                    m_lock_idx = g;
                end
            end else begin
                m_wb_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gen();
        for (int i = 0; i < NUM_REQS; i++) begin
            if (i == last_acc) src_vld[i] = 1'b0;
            if (!src_vld[i] && $urandom_range(0, 2) == 0) begin
                src_vld[i]  = 1'b1;
                src_beat[i] = rand_beat(1'($urandom_range(0, 2) != 0));
            end
        end
    endtask

    function automatic bit any_pending();
        bit a;
        a = m_lock;
        for (int i = 0; i < NUM_REQS; i++) a |= src_vld[i];
        return a;
    endfunction

    // Let every pending beat retire, closing an open lock with an eop beat.
    task automatic drain();
        int n;
        n = 0;
        tb_wb_ready = 1'b1;
        while (any_pending() && n < 64) begin
            if (m_lock && !src_vld[m_lock_idx]) begin
                src_vld[m_lock_idx]  = 1'b1;
                src_beat[m_lock_idx] = rand_beat(1'b1);
            end
            step();
            if (last_acc >= 0) src_vld[last_acc] = 1'b0;
            n++;
        end
        check("drain_done", 192'(any_pending()), 192'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]           alt_pc [4];
        logic [PERF_CTR_W-1:0] p0;

        alt_pc = '{32'h100, 32'h200, 32'h101, 32'h201};
        for (int i = 0; i < NUM_REQS; i++) begin
            src_vld[i]  = 1'b0;
            src_beat[i] = '0;
        end
        tb_wb_ready = 1'b1;
        reset       = 1'b0;
        model_reset();

        // Ready is masked while reset is held, even with a valid request.
        src_vld[WB_SRC_ALU]  = 1'b1;
        src_beat[WB_SRC_ALU] = mk_beat(32'h40, 1'b1);
        drive();
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", 192'(bus.req_ready), 192'(0));
        check("rst_wb_valid", 192'(bus.wb_valid), 192'(0));
        check("rst_perf", 192'(perf_wb_stalls), 192'(0));
        src_vld[WB_SRC_ALU] = 1'b0;
        drive();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_wb_valid", 192'(bus.wb_valid), 192'(0));

        // ALU and LD both always valid: strict alternation, one stall per cycle.
        src_vld[WB_SRC_ALU]  = 1'b1;
        src_beat[WB_SRC_ALU] = mk_beat(32'h100, 1'b1);
        src_vld[WB_SRC_LD]   = 1'b1;
        src_beat[WB_SRC_LD]  = mk_beat(32'h200, 1'b1);
        p0 = perf_wb_stalls;
        for (int n = 0; n < 4; n++) begin
            step();
            check("alt_pc", 192'(bus.wb_pc), 192'(alt_pc[n]));
            if (last_acc >= 0)
                src_beat[last_acc] = mk_beat(src_beat[last_acc].pc + 32'd1, 1'b1);
        end
        check("alt_perf", 192'(perf_wb_stalls - p0), 192'(4));
        drain();

        // GPU multi-beat commit locks out FPU, including through a GPU bubble.
        src_vld[WB_SRC_GPU]  = 1'b1;
        src_beat[WB_SRC_GPU] = mk_beat(32'h500, 1'b0);
        step();
        check("lock_pc0", 192'(bus.wb_pc), 192'(32'h500));
        src_beat[WB_SRC_GPU] = mk_beat(32'h504, 1'b0);
        src_vld[WB_SRC_FPU]  = 1'b1;
        src_beat[WB_SRC_FPU] = mk_beat(32'h400, 1'b1);
        step();
        check("lock_pc1", 192'(bus.wb_pc), 192'(32'h504));
        check("lock_fpu_rdy1", 192'(obs_ready[WB_SRC_FPU]), 192'(0));
        src_vld[WB_SRC_GPU] = 1'b0;
        step();
        check("bubble_ready", 192'(obs_ready), 192'(0));
        check("bubble_valid", 192'(bus.wb_valid), 192'(0));
        src_vld[WB_SRC_GPU]  = 1'b1;
        src_beat[WB_SRC_GPU] = mk_beat(32'h508, 1'b1);
        step();
        check("lock_pc2", 192'(bus.wb_pc), 192'(32'h508));
        check("lock_fpu_rdy2", 192'(obs_ready[WB_SRC_FPU]), 192'(0));
        src_vld[WB_SRC_GPU] = 1'b0;
        step();
        check("after_lock_pc", 192'(bus.wb_pc), 192'(32'h400));
        src_vld[WB_SRC_FPU] = 1'b0;

        // Last grant was FPU, so GPU wins before ALU, then the pointer wraps.
        src_vld[WB_SRC_ALU]  = 1'b1;
        src_beat[WB_SRC_ALU] = mk_beat(32'h600, 1'b1);
        src_vld[WB_SRC_GPU]  = 1'b1;
        src_beat[WB_SRC_GPU] = mk_beat(32'h650, 1'b1);
        step();
        check("wrap_first", 192'(bus.wb_pc), 192'(32'h650));
        src_vld[WB_SRC_GPU] = 1'b0;
        step();
        check("wrap_second", 192'(bus.wb_pc), 192'(32'h600));
        src_vld[WB_SRC_ALU] = 1'b0;

        // Output held under backpressure; ALU keeps requesting and counts stalls.
        src_vld[WB_SRC_ALU]  = 1'b1;
        src_beat[WB_SRC_ALU] = mk_beat(32'h8000_0010, 1'b1);
        step();
        check("stall_load_pc", 192'(bus.wb_pc), 192'(32'h8000_0010));
        src_beat[WB_SRC_ALU] = mk_beat(32'h8000_0020, 1'b1);
        tb_wb_ready = 1'b0;
        p0 = perf_wb_stalls;
        for (int n = 0; n < 3; n++) begin
            step();
            check("stall_pc", 192'(bus.wb_pc), 192'(32'h8000_0010));
            check("stall_valid", 192'(bus.wb_valid), 192'(1));
            check("stall_ready", 192'(obs_ready), 192'(0));
        end
        check("stall_perf", 192'(perf_wb_stalls - p0), 192'(3));
        drain();

        // Store commit forwarded with wb=0.
        src_vld[WB_SRC_ST]        = 1'b1;
        src_beat[WB_SRC_ST]       = mk_beat(32'h700, 1'b1);
        src_beat[WB_SRC_ST].wb    = 1'b0;
        src_beat[WB_SRC_ST].rd    = '0;
        src_beat[WB_SRC_ST].tmask = 4'b1011;
        step();
        check("st_wb", 192'(bus.wb_wb), 192'(0));
        check("st_tmask", 192'(bus.wb_tmask), 192'(4'b1011));
        src_vld[WB_SRC_ST] = 1'b0;
        drain();

        // Random traffic with random backpressure.
        for (int n = 0; n < 1500; n++) begin
            tb_wb_ready = 1'($urandom_range(0, 3) != 0);
            gen();
            step();
        end
        if (last_acc >= 0) src_vld[last_acc] = 1'b0;
        drain();

        // Asynchronous reset while the output holds a beat.
        src_vld[WB_SRC_CSR]  = 1'b1;
        src_beat[WB_SRC_CSR] = mk_beat(32'h900, 1'b1);
        step();
        src_vld[WB_SRC_CSR] = 1'b0;
        check("pre_rst_valid", 192'(bus.wb_valid), 192'(1));
        #2;
        reset = 1'b0;
        drive();
        #1;
        check("async_wb_valid", 192'(bus.wb_valid), 192'(0));
        check("async_perf", 192'(perf_wb_stalls), 192'(0));
        check("async_pc", 192'(bus.wb_pc), 192'(0));
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel2_wb_valid", 192'(bus.wb_valid), 192'(0));

        for (int n = 0; n < 300; n++) begin
            tb_wb_ready = 1'($urandom_range(0, 3) != 0);
            gen();
            step();
        end
        if (last_acc >= 0) src_vld[last_acc] = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_writeback_arb.md
Name: vx_writeback_arb

Overview:
- Arbitrates the per-unit commit streams (ALU, LD, ST, CSR, FPU, GPU) onto the single register-file writeback port.
- Grants are round-robin. A source that starts a multi-beat commit (eop=0) holds the grant until its eop beat is accepted.
- Output is registered, with one-cycle latency and full ready/valid backpressure, plus a stall counter for the perf CSRs.

Parameters:
- NUM_REQS, 6, number of commit sources (index 0 = ALU … 5 = GPU).
- NUM_THREADS, 4, lanes per commit; data width DATA_W = NUM_THREADS*32.
- NW_BITS, 2, warp-id width.
- NR_BITS, 6, destination register index width (int+fp file).
- PERF_CTR_W, 44, width of the stall counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQS  per-source commit valid.
- req_wid  in  NUM_REQS*NW_BITS  warp id.
- req_pc  in  NUM_REQS*32  instruction PC.
- req_tmask  in  NUM_REQS*NUM_THREADS  thread mask.
- req_rd  in  NUM_REQS*NR_BITS  destination register.
- req_wb  in  NUM_REQS  writes a register.
- req_data  in  NUM_REQS*DATA_W  lane results.
- req_eop  in  NUM_REQS  last beat of this commit.
- req_ready  out  NUM_REQS  per-source accept.
- wb_valid  out  1  writeback valid.
- wb_wid, wb_pc, wb_tmask, wb_rd, wb_wb, wb_data, wb_eop  out  widths as above  registered winner payload.
- wb_ready  in  1  writeback consumer ready.
- perf_wb_stalls  out  PERF_CTR_W  cycles in which at least one valid request was not accepted.

Behaviour:
- Reset (reset=0, async) clears the following:
  - wb_valid=0 and all wb_* payload=0;
  - rr_ptr=0, lock=0, lock_idx=0;
  - perf_wb_stalls=0.
  - req_ready is 0 while in reset.
- Releasing reset mid-operation is clean: all in-flight state is discarded, and no beat is emitted on the first cycle after release.
- stall = wb_valid & ~wb_ready. The output register loads only when ~stall.
- Grant selection (combinational):
  - If lock=1, grant = onehot(lock_idx) when req_valid[lock_idx]=1, else no grant. Other sources wait even while the locked source bubbles.
  - If lock=0, round-robin: the first valid index at or after rr_ptr, scanning upward modulo NUM_REQS.
- req_ready[i] = grant[i] & ~stall. A beat is accepted when req_valid[i] & req_ready[i]. At most one source is accepted per cycle.
- On accept, on the next clk edge:
  - wb_valid=1 and the payload is copied from the winner.
  - If eop=0: lock=1, lock_idx=i.
  - If eop=1: lock=0, rr_ptr = (i+1) mod NUM_REQS.
- When ~stall and no beat is accepted, wb_valid goes to 0 on the next edge.
- Latency: accept to wb_valid is 1 cycle. Throughput is 1 beat/cycle when wb_ready=1.
- wb_* is held stable while stall=1.
- rr_ptr wraps from NUM_REQS-1 to 0. rr_ptr is not changed by locked or non-eop beats.
- When several sources are valid simultaneously, only the grant winner sees ready. The others must hold their payload, per the valid/ready rule.
- Requests with req_wb=0 (stores, fences) are forwarded like any other, so commit accounting sees them. The register file ignores wb_wb=0.
- perf_wb_stalls increments by 1 in any cycle where |(req_valid & ~req_ready) = 1, and saturates at all-ones.
- Assertions (simulation only):
  - a source never drops valid before it is accepted;
  - exactly zero or one bit of req_valid & req_ready is set.

Decomposition:
- Shared package vx_wb_pkg holds:
  - the source index constants WB_SRC_ALU=0, LD=1, ST=2, CSR=3, FPU=4, GPU=5;
  - the wb_beat_t packed struct {wid, pc, tmask, rd, wb, data, eop};
  - parameter defaults.
- One sub-module: vx_rr_lock_arbiter (parameter NUM_REQS). Inputs: valid vector, lock, lock_idx, rr_ptr. Output: one-hot grant plus an encoded index. It is purely combinational and reusable for the tex/LSU dcache sharing.
- The top level keeps the output register, the lock/pointer state and the perf counter.

Test Plan:
- Reset with wb_valid previously 1 → wb_valid=0, perf=0 asynchronously, before the next clk edge; after release, the first edge outputs nothing.
- ALU and LD are both valid with eop=1 continuously for 4 cycles and wb_ready=1 → outputs alternate ALU, LD, ALU, LD; each request is accepted every other cycle; perf increments 4.
- GPU sends 3 beats (eop=0,0,1) while FPU is valid throughout → wb shows GPU, GPU, GPU, then FPU; FPU's req_ready stays 0 during the lock, including a GPU bubble cycle.
- wb_ready=0 for 3 cycles with wb_valid=1 (pc=0x8000_0010) → wb_* stays constant; all req_ready=0; perf increments 3 (ALU valid).
- rr_ptr=5 (last grant was index 4), with sources 0 and 5 both valid → source 5 is granted, then source 0 (wrap).
- Store commit with req_wb=0, rd=0, tmask=4'b1011 on source 2 → wb_wb=0 and wb_tmask=4'b1011 appear one cycle later.
